rom_fetch_bridge: RTL and testbench
===================================

// Module: rom_fetch_bridge
// PURPOSE
//  Parametrised program-memory fetch bridge between a byte-fetching CPU core (tms1x00 class) and a
//  WORD_BYTES-wide single-port SRAM macro. Returns byte lane addr[LB-1:0] of the fetched word.
//  Holds a one-word line buffer so sequential fetches within a word skip the macro. Arbitrates a
//  host loader write port (Wishbone-side program upload) against CPU fetches. Counts misses for bring-up.
// PARAMETERS
//  ADDR_W      11  CPU byte-address width
//  WORD_BYTES  4   bytes per SRAM word (power of 2, >=2); LB=log2(WORD_BYTES), WA_W=ADDR_W-LB
//  RD_LAT      1   SRAM read latency in cycles (>=1), dout valid RD_LAT cycles after csb-low edge
//  CNT_W       16  width of miss counter
// PORTS
//  wb_clk_i    in   1             single clock, all logic rising-edge
//  wb_rst_i    in   1             asynchronous, active-high reset
//  cpu_req     in   1             fetch request; held with cpu_addr until cpu_ack
//  cpu_addr    in   ADDR_W        byte address
//  cpu_ack     out  1             one-cycle pulse, cpu_data valid this cycle
//  cpu_data    out  8             fetched byte, held until next ack
//  ld_valid    in   1             loader write request
//  ld_addr     in   WA_W          loader word address
//  ld_data     in   8*WORD_BYTES  loader write data
//  ld_wmask    in   WORD_BYTES    per-byte write enable
//  ld_ready    out  1             loader write accepted when ld_valid&ld_ready
//  flush       in   1             invalidate line buffer
//  sram_csb    out  1             macro chip select, active low
//  sram_web    out  1             macro write enable, active low
//  sram_addr   out  WA_W          macro word address
//  sram_wmask  out  WORD_BYTES    macro byte mask
//  sram_din    out  8*WORD_BYTES  macro write data
//  sram_dout   in   8*WORD_BYTES  macro read data
//  miss_cnt    out  CNT_W         saturating count of line misses
// BEHAVIOUR
//  Reset (async): state=IDLE, line_valid=0, line_tag=0, line_data=0, cpu_ack=0, cpu_data=0,
//   sram_csb=1, sram_web=1, sram_addr=0, sram_wmask=0, sram_din=0, miss_cnt=0. ld_ready=0 while wb_rst_i=1.
//  ld_ready = (state==IDLE) & ~wb_rst_i (combinational). All sram_* outputs registered.
//  FSM states IDLE, WRITE, READ, WAIT, RESP:
//   IDLE: ld_valid -> WRITE (loader wins over simultaneous cpu_req); drive csb=0,web=0,addr/din/wmask=ld_*.
//         else cpu_req & hit (line_valid & line_tag==cpu_addr[ADDR_W-1:LB]) -> RESP, cpu_data=lane.
//         else cpu_req (miss) -> READ; csb=0,web=1,addr=cpu word addr; miss_cnt+1 (saturates at all-ones).
//   WRITE: csb=1,web=1 -> IDLE. If ld_addr==line_tag, line_valid cleared (no merge).
//   READ: csb=1; wait counter loaded RD_LAT-1; counter==0 -> capture sram_dout into line_data,
//         line_tag=word addr, line_valid=1, cpu_data=lane -> RESP; else -> WAIT.
//   WAIT: decrement; at 0 capture as in READ -> RESP.
//   RESP: cpu_ack=1 for exactly this cycle -> IDLE.
//  Lane select: cpu_data = line/dout bits [8*k+7:8*k], k=cpu_addr[LB-1:0] (byte-granular shift, not bit).
//  Latency (req seen in IDLE at cycle 0): hit ack at cycle 1; miss ack at cycle RD_LAT+2.
//  Earliest next request accepted the cycle after ack (IDLE). cpu_addr sampled only in IDLE;
//   changes while not IDLE are ignored until the next IDLE.
//  flush: clears line_valid next edge in any state; flush in same cycle as capture -> valid ends 0,
//   current response still delivered. flush plus hit in IDLE: hit is served, line then invalid.
//  Loader writes never interrupt READ/WAIT/RESP; ld_ready low there, host must hold ld_valid.
//  Reset mid-read: ack never issued; CPU re-requests after reset release.
// TESTING
//  Reset, then cpu_req addr=0x005, mem[1]=0xDDCCBBAA, RD_LAT=1 -> ack at cycle 3, data=0xBB, miss_cnt=1.
//  Follow with addr=0x007 -> ack 1 cycle after req, data=0xDD, miss_cnt stays 1, sram_csb stays 1.
//  ld_valid & cpu_req same cycle, ld_addr=1,ld_data=0x11223344,wmask=4'b0011 -> write first, line
//   invalidated, then fetch addr=0x004 misses, returns 0x44 (mem[1]=0xDDCC3344).
//  RD_LAT=3 build: miss ack exactly 5 cycles after req; ld_ready low all 5 cycles.
//  Assert wb_rst_i during WAIT -> outputs reset immediately, no cpu_ack, line_valid=0 afterwards.
//  Force 2^CNT_W+3 misses (alternating words) with CNT_W=4 -> miss_cnt holds 4'hF.

Source files
------------

// File: rtl/rom_fetch_bridge.sv
// rtl/rom_fetch_bridge.sv - byte fetch bridge to a word-wide SRAM with a one-word line buffer and loader write port
module rom_fetch_bridge #(
    parameter int ADDR_W     = 11,
    parameter int WORD_BYTES = 4,
    parameter int RD_LAT     = 1,
    parameter int CNT_W      = 16,
    localparam int LB        = $clog2(WORD_BYTES),
    localparam int WA_W      = ADDR_W - LB,
    localparam int DW        = 8 * WORD_BYTES
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_data,
    input  logic              ld_valid,
    input  logic [WA_W-1:0]   ld_addr,
    input  logic [DW-1:0]     ld_data,
    input  logic [WORD_BYTES-1:0] ld_wmask,
    output logic              ld_ready,
    input  logic              flush,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [WA_W-1:0]   sram_addr,
    output logic [WORD_BYTES-1:0] sram_wmask,
    output logic [DW-1:0]     sram_din,
    input  logic [DW-1:0]     sram_dout,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    line_valid_q, line_valid_d;
    logic [WA_W-1:0]         line_tag_q, line_tag_d;
    logic [DW-1:0]           line_data_q, line_data_d;
    logic                    cpu_ack_q, cpu_ack_d;
    logic [7:0]              cpu_data_q, cpu_data_d;
    logic                    sram_csb_q, sram_csb_d;
    logic                    sram_web_q, sram_web_d;
    logic [WA_W-1:0]         sram_addr_q, sram_addr_d;
    logic [WORD_BYTES-1:0]   sram_wmask_q, sram_wmask_d;
    logic [DW-1:0]           sram_din_q, sram_din_d;
    logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;
    logic [WC_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic [LB-1:0]           lane_q, lane_d;
    logic                    hit;

    assign hit = line_valid_q && (line_tag_q == cpu_addr[ADDR_W-1:LB]);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            line_data_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_data_q   <= '0;
            sram_csb_q   <= 1'b1;
            sram_web_q   <= 1'b1;
            sram_addr_q  <= '0;
            sram_wmask_q <= '0;
            sram_din_q   <= '0;
            miss_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            lane_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            line_data_q  <= line_data_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_data_q   <= cpu_data_d;
            sram_csb_q   <= sram_csb_d;
            sram_web_q   <= sram_web_d;
            sram_addr_q  <= sram_addr_d;
            sram_wmask_q <= sram_wmask_d;
            sram_din_q   <= sram_din_d;
            miss_cnt_q   <= miss_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            lane_q       <= lane_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        cpu_ack_d    = 1'b0;
        cpu_data_d   = cpu_data_q;
        sram_csb_d   = 1'b1;
        sram_web_d   = 1'b1;
        sram_addr_d  = sram_addr_q;
        sram_wmask_d = sram_wmask_q;
        sram_din_d   = sram_din_q;
        miss_cnt_d   = miss_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        lane_d       = lane_q;
        case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    state_d      = S_WRITE;
                    sram_csb_d   = 1'b0;
                    sram_web_d   = 1'b0;
                    sram_addr_d  = ld_addr;
                    sram_din_d   = ld_data;
                    sram_wmask_d = ld_wmask;
                end else if (cpu_req && hit) begin
                    state_d    = S_RESP;
                    cpu_ack_d  = 1'b1;
                    cpu_data_d = line_data_q[{cpu_addr[LB-1:0], 3'b000} +: 8];
                end else if (cpu_req) begin
                    state_d     = S_READ;
                    sram_csb_d  = 1'b0;
                    sram_addr_d = cpu_addr[ADDR_W-1:LB];
                    lane_d      = cpu_addr[LB-1:0];
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // No merge into the line buffer: a write to the buffered word just drops it.
                if (sram_addr_q == line_tag_q) begin
                    line_valid_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            S_READ: begin
                wait_cnt_d = WC_W'(RD_LAT - 1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    line_data_d  = sram_dout;
                    line_tag_d   = sram_addr_q;
                    line_valid_d = 1'b1;
                    cpu_data_d   = sram_dout[{lane_q, 3'b000} +: 8];
                    cpu_ack_d    = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flush wins over a same-cycle capture; the response itself is still delivered.
        if (flush) begin
            line_valid_d = 1'b0;
        end
    end

    assign ld_ready   = (state_q == S_IDLE) && !wb_rst_i;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_data   = cpu_data_q;
    assign sram_csb   = sram_csb_q;
    assign sram_web   = sram_web_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wmask = sram_wmask_q;
    assign sram_din   = sram_din_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// tb/tb_rom_fetch_bridge.sv - randomized self-checking bench for rom_fetch_bridge, RD_LAT 1 and 3 instances
module tb_rom_fetch_bridge;
    localparam int ADDR_W = 11;
    localparam int WB     = 4;
    localparam int LB     = 2;
    localparam int WA_W   = 9;
    localparam int DW     = 32;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst        [2];
    logic              cpu_req    [2];
    logic [ADDR_W-1:0] cpu_addr   [2];
    logic              cpu_ack    [2];
    logic [7:0]        cpu_data   [2];
    logic              ld_valid   [2];
    logic [WA_W-1:0]   ld_addr    [2];
    logic [DW-1:0]     ld_data    [2];
    logic [WB-1:0]     ld_wmask   [2];
    logic              ld_ready   [2];
    logic              flush      [2];
    logic              sram_csb   [2];
    logic              sram_web   [2];
    logic [WA_W-1:0]   sram_addr  [2];
    logic [WB-1:0]     sram_wmask [2];
    logic [DW-1:0]     sram_din   [2];
    logic [DW-1:0]     sram_dout  [2];
    logic [CNT_W-1:0]  miss_cnt   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rom_fetch_bridge #(
            .ADDR_W(ADDR_W), .WORD_BYTES(WB), .RD_LAT(g == 0 ? 1 : 3), .CNT_W(CNT_W)
        ) u_dut (
            .wb_clk_i(clk), .wb_rst_i(rst[g]),
            .cpu_req(cpu_req[g]), .cpu_addr(cpu_addr[g]), .cpu_ack(cpu_ack[g]), .cpu_data(cpu_data[g]),
            .ld_valid(ld_valid[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g]), .ld_wmask(ld_wmask[g]),
            .ld_ready(ld_ready[g]), .flush(flush[g]),
            .sram_csb(sram_csb[g]), .sram_web(sram_web[g]), .sram_addr(sram_addr[g]),
            .sram_wmask(sram_wmask[g]), .sram_din(sram_din[g]), .sram_dout(sram_dout[g]),
            .miss_cnt(miss_cnt[g])
        );
    end

    // Reference model: word-level memory image, line buffer tag/valid, saturating miss count
    logic [DW-1:0]   ref_mem   [2][DEPTH];
    bit              ref_valid [2];
    logic [WA_W-1:0] ref_tag   [2];
    int              ref_miss  [2];

    // SRAM macro models; contents seeded from the reference image while in reset
    logic [DW-1:0] mem     [2][DEPTH];
    logic [DW-1:0] rd_pipe [2][3];
    bit            mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < DEPTH; i++) mem[g][i] <= ref_mem[g][i];
            mem_ready <= 1'b1;
        end
        for (int g = 0; g < 2; g++) begin
            if (!sram_csb[g] && !sram_web[g]) begin
                for (int b = 0; b < WB; b++)
                    if (sram_wmask[g][b]) mem[g][sram_addr[g]][8*b +: 8] <= sram_din[g][8*b +: 8];
            end
            for (int i = 2; i > 0; i--) rd_pipe[g][i] <= rd_pipe[g][i-1];
            if (!sram_csb[g] && sram_web[g]) rd_pipe[g][0] <= mem[g][sram_addr[g]];
        end
    end
    assign sram_dout[0] = rd_pipe[0][0];
    assign sram_dout[1] = rd_pipe[1][2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int g);
        ref_valid[g] = 1'b0;
        ref_tag[g]   = '0;
        ref_miss[g]  = 0;
    endtask

    task automatic rst_outputs(input int g);
        chk("rst_ack", cpu_ack[g], 0);
        chk("rst_data", cpu_data[g], 0);
        chk("rst_csb", sram_csb[g], 1);
        chk("rst_web", sram_web[g], 1);
        chk("rst_addr", sram_addr[g], 0);
        chk("rst_wmask", sram_wmask[g], 0);
        chk("rst_din", sram_din[g], 0);
        chk("rst_miss", miss_cnt[g], 0);
        chk("rst_ld_ready", ld_ready[g], 0);
    endtask

    task automatic pulse_reset(input int g);
        rst[g] = 1'b1;
        #1;
        rst_outputs(g);
        @(posedge clk); #1;
        rst[g] = 1'b0;
        model_reset(g);
    endtask

    // fmode: 0 none, 1 flush alongside the request, 2 flush in the capture cycle. pre: cycles before DUT is IDLE.
    task automatic fetch(input int g, input logic [ADDR_W-1:0] a, input int fmode, input int pre,
                         output logic [7:0] got);
        logic [WA_W-1:0] w;
        logic [DW-1:0]   wd;
        logic [7:0]      exp_d;
        bit              hit, csb_seen, rdy_seen;
        int              exp_lat, n;
        w       = a[ADDR_W-1:LB];
        hit     = ref_valid[g] && (ref_tag[g] == w);
        exp_lat = (hit ? 1 : lat_of(g) + 2) + pre;
        wd      = ref_mem[g][w];
        exp_d   = wd[{a[LB-1:0], 3'b000} +: 8];
        if (!hit) begin
            ref_tag[g] = w;
            if (ref_miss[g] != (1 << CNT_W) - 1) ref_miss[g]++;
        end
        ref_valid[g] = hit ? (fmode != 1) : (fmode != 2);
        cpu_req[g]  = 1'b1;
        cpu_addr[g] = a;
        if (fmode == 1) flush[g] = 1'b1;
        n = 0; csb_seen = 0; rdy_seen = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            flush[g] = 1'b0;
            if (fmode == 2 && n == exp_lat - 1) flush[g] = 1'b1;
            if (n > pre) begin
                if (!sram_csb[g]) csb_seen = 1;
                if (ld_ready[g]) rdy_seen = 1;
            end
            if (cpu_ack[g]) break;
        end
        chk("ack_latency", n, exp_lat);
        chk("fetch_data", cpu_data[g], exp_d);
        chk("sram_read_issued", csb_seen, !hit);
        chk("ld_ready_busy", rdy_seen, 0);
        got = cpu_data[g];
        cpu_req[g] = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", cpu_ack[g], 0);
        chk("data_held", cpu_data[g], exp_d);
        chk("miss_cnt", miss_cnt[g], ref_miss[g]);
    endtask

    task automatic load(input int g, input logic [WA_W-1:0] wa, input logic [DW-1:0] d, input logic [WB-1:0] m);
        int n;
        ld_valid[g] = 1'b1;
        ld_addr[g]  = wa;
        ld_data[g]  = d;
        ld_wmask[g] = m;
        n = 0;
        while (!ld_ready[g] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ld_ready_idle", ld_ready[g], 1);
        @(posedge clk); #1;
        ld_valid[g] = 1'b0;
        chk("wr_strobe", {sram_csb[g], sram_web[g]}, 2'b00);
        chk("wr_addr", sram_addr[g], wa);
        chk("wr_din", sram_din[g], d);
        chk("wr_mask", sram_wmask[g], m);
        chk("ld_ready_wr", ld_ready[g], 0);
        for (int b = 0; b < WB; b++)
            if (m[b]) ref_mem[g][wa][8*b +: 8] = d[8*b +: 8];
        if (ref_tag[g] == wa) ref_valid[g] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]        d;
        logic [ADDR_W-1:0] a;
        bit                seen;
        int                r;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; cpu_req[g] = 1'b0; cpu_addr[g] = '0; flush[g] = 1'b0;
            ld_valid[g] = 1'b0; ld_addr[g] = '0; ld_data[g] = '0; ld_wmask[g] = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[g][i] = $urandom;
            ref_mem[g][1] = 32'hDDCCBBAA;
            model_reset(g);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) rst_outputs(g);
        for (int g = 0; g < 2; g++) rst[g] = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) chk("ld_ready_after_rst", ld_ready[g], 1);

        fetch(0, 11'h005, 0, 0, d);
        chk("t1_data", d, 8'hBB);
        chk("t1_miss", miss_cnt[0], 1);
        fetch(0, 11'h007, 0, 0, d);
        chk("t2_data", d, 8'hDD);
        chk("t2_miss", miss_cnt[0], 1);

        cpu_req[0]  = 1'b1;
        cpu_addr[0] = 11'h004;
        load(0, 9'd1, 32'h11223344, 4'b0011);
        chk("t3_no_ack_during_wr", cpu_ack[0], 0);
        fetch(0, 11'h004, 0, 1, d);
        chk("t3_data", d, 8'h44);
        chk("t3_miss", miss_cnt[0], 2);

        fetch(1, 11'h005, 0, 0, d);
        chk("t4_data", d, 8'hBB);

        fetch(0, 11'h005, 1, 0, d);
        chk("flush_hit_data", d, 8'h33);
        fetch(0, 11'h006, 0, 0, d);
        chk("after_flush_data", d, 8'hCC);
        chk("after_flush_miss", miss_cnt[0], 3);
        fetch(0, 11'h00A, 2, 0, d);
        fetch(0, 11'h00B, 0, 0, d);

        cpu_req[1]  = 1'b1;
        cpu_addr[1] = 11'h020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst[1] = 1'b1;
        #1;
        rst_outputs(1);
        cpu_req[1] = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (cpu_ack[1]) seen = 1;
        end
        chk("rst_no_ack", seen, 0);
        rst[1] = 1'b0;
        model_reset(1);
        fetch(1, 11'h020, 0, 0, d);
        chk("rst_refetch_miss", miss_cnt[1], 1);

        pulse_reset(0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            fetch(0, (i % 2) ? 11'h010 : 11'h014, 0, 0, d);
        chk("miss_saturated", miss_cnt[0], 4'hF);

        for (int g = 0; g < 2; g++) begin
            pulse_reset(g);
            for (int k = 0; k < 80; k++) begin
                r = $urandom_range(0, 9);
                a = ADDR_W'($urandom_range(0, 31));
                if (r <= 4) begin
                    fetch(g, a, 0, 0, d);
                end else if (r == 5) begin
                    fetch(g, a, $urandom_range(1, 2), 0, d);
                end else if (r <= 7) begin
                    load(g, WA_W'($urandom_range(0, 7)), $urandom, WB'($urandom_range(0, 15)));
                    @(posedge clk); #1;
                end else if (r == 8) begin
                    flush[g] = 1'b1;
                    @(posedge clk); #1;
                    flush[g] = 1'b0;
                    ref_valid[g] = 1'b0;
                end else begin
                    cpu_req[g]  = 1'b1;
                    cpu_addr[g] = a;
                    load(g, WA_W'($urandom_range(0, 7)), $urandom, WB'($urandom_range(0, 15)));
                    fetch(g, a, 0, 1, d);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
